// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, requester ids, FIFO entry.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} sched_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous FIFO with registered count; full/empty derive from the count.
module tx_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin TX scheduler between core and debug byte FIFOs feeding one UART sender.
// Define UART_TX_SCHED_LOCK_EN to keep records (terminated by last) from interleaving.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] core_data,
    input  logic          core_valid,
    input  logic          core_last,
    output logic          core_ready,
    input  logic [DW-1:0] dbg_data,
    input  logic          dbg_valid,
    input  logic          dbg_last,
    output logic          dbg_ready,
    output logic [DW-1:0] tx_data,
    output logic          tx_start,
    input  logic          tx_done,
    output logic          busy
);
`ifdef UART_TX_SCHED_LOCK_EN
    localparam int EW = $bits(fifo_entry_t);
    fifo_entry_t core_ent, dbg_ent, gnt_e;
    logic        locked;
`else
    localparam int EW = DW;
    logic        unused_last;
    assign unused_last = core_last ^ dbg_last;
`endif

    logic [EW-1:0]          core_wr, dbg_wr, core_rd, dbg_rd, gnt_rd;
    logic                   core_full, dbg_full, core_empty, dbg_empty;
    logic [$clog2(DEPTH):0] unused_core_cnt, unused_dbg_cnt;
    logic                   core_ne_q, dbg_ne_q, core_elig, dbg_elig;
    logic                   rr, gnt, go, core_pop, dbg_pop;
    sched_state_t           state;

`ifdef UART_TX_SCHED_LOCK_EN
    assign core_ent = '{last: core_last, data: core_data};
    assign dbg_ent  = '{last: dbg_last,  data: dbg_data};
    assign core_wr  = core_ent;
    assign dbg_wr   = dbg_ent;
    assign gnt_e    = gnt_rd;
`else
    assign core_wr  = core_data;
    assign dbg_wr   = dbg_data;
`endif

    tx_byte_fifo #(.DEPTH(DEPTH), .W(EW)) u_core_fifo (
        .CLK(CLK), .RST(RST), .push(core_valid), .push_data(core_wr), .pop(core_pop),
        .pop_data(core_rd), .full(core_full), .empty(core_empty), .count(unused_core_cnt)
    );

    tx_byte_fifo #(.DEPTH(DEPTH), .W(EW)) u_dbg_fifo (
        .CLK(CLK), .RST(RST), .push(dbg_valid), .push_data(dbg_wr), .pop(dbg_pop),
        .pop_data(dbg_rd), .full(dbg_full), .empty(dbg_empty), .count(unused_dbg_cnt)
    );

    assign core_ready = ~core_full;
    assign dbg_ready  = ~dbg_full;
    assign busy       = ~core_empty | ~dbg_empty | (state != IDLE);

    // Eligibility uses a registered non-empty flag so a fresh byte waits one extra cycle
    always_comb begin
        core_elig = core_ne_q & ~core_empty;
        dbg_elig  = dbg_ne_q & ~dbg_empty;
`ifdef UART_TX_SCHED_LOCK_EN
        if (locked) begin
            core_elig = core_elig & (rr == REQ_CORE);
            dbg_elig  = dbg_elig & (rr == REQ_DBG);
        end
`endif
    end

    assign gnt      = (core_elig & dbg_elig) ? rr : dbg_elig;
    assign go       = (state == IDLE) & tx_done & (core_elig | dbg_elig);
    assign core_pop = go & (gnt == REQ_CORE);
    assign dbg_pop  = go & (gnt == REQ_DBG);
    assign gnt_rd   = (gnt == REQ_DBG) ? dbg_rd : core_rd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rr        <= REQ_CORE;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            core_ne_q <= 1'b0;
            dbg_ne_q  <= 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            core_ne_q <= ~core_empty;
            dbg_ne_q  <= ~dbg_empty;
            tx_start  <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    tx_start <= 1'b1;
                    tx_data  <= gnt_rd[DW-1:0];
                    state    <= WAIT_ACK;
`ifdef UART_TX_SCHED_LOCK_EN
                    locked   <= ~gnt_e.last;
                    rr       <= gnt_e.last ? ~gnt : gnt;
`else
                    rr       <= ~gnt;
`endif
                end
                WAIT_ACK:  if (!tx_done) state <= WAIT_DONE;
                WAIT_DONE: if (tx_done)  state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table plus hand-written corner sequences.
module tb_uart_tx_sched;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] core_data = 8'h00, dbg_data = 8'h00;
    logic       core_valid = 1'b0, core_last = 1'b1, dbg_valid = 1'b0, dbg_last = 1'b1;
    logic       core_ready, dbg_ready, tx_start, busy;
    logic [7:0] tx_data;
    logic       tx_done = 1'b1;

    int errors = 0, checks = 0;
    int cyc = 0, last_start = -1, nstarts = 0, dcnt = 0;
    logic [7:0] sb[$];

    uart_tx_sched #(.DEPTH(16), .DW(8)) dut (
        .CLK(CLK), .RST(RST),
        .core_data(core_data), .core_valid(core_valid), .core_last(core_last), .core_ready(core_ready),
        .dbg_data(dbg_data), .dbg_valid(dbg_valid), .dbg_last(dbg_last), .dbg_ready(dbg_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Sender model: done drops one cycle after start, stays low 20 cycles; never reset
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            tx_done <= 1'b0;
            dcnt    <= 20;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) tx_done <= 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        if (tx_start) begin
            nstarts++;
            last_start = cyc;
            check("start_with_sender_idle", int'(tx_done), 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: tx_data=%0h with nothing expected", tx_data);
            end else begin
                check("tx_data_order", int'(tx_data), int'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || !tx_done) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(n < budget), 1);
    endtask

    task automatic wait_start(input int budget);
        int n0 = nstarts;
        int n = 0;
        while (nstarts == n0 && n < budget) begin
            tick();
            n++;
        end
        check("start_timeout", int'(n < budget), 1);
    endtask

    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       dv;
        logic [7:0] dd;
        logic [7:0] e0;
        logic [7:0] e1;
        int         n;
        logic       rst;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int acc, s1, n, ns;

        tbl[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 8'h41, 8'h00, 1, 1'b1};
        tbl[1] = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h11, 8'h22, 2, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h5A, 8'h5A, 8'h00, 1, 1'b0};
        tbl[3] = '{1'b1, 8'h66, 1'b0, 8'h00, 8'h66, 8'h00, 1, 1'b0};
        tbl[4] = '{1'b1, 8'h77, 1'b1, 8'h88, 8'h88, 8'h77, 2, 1'b0};

        reset_dut();
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_core_ready", int'(core_ready), 1);
        check("rst_dbg_ready", int'(dbg_ready), 1);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].rst) reset_dut();
            sb.push_back(tbl[i].e0);
            if (tbl[i].n == 2) sb.push_back(tbl[i].e1);
            core_valid = tbl[i].cv; core_data = tbl[i].cd;
            dbg_valid  = tbl[i].dv; dbg_data  = tbl[i].dd;
            tick();
            acc = cyc;
            core_valid = 1'b0; dbg_valid = 1'b0;
            check("busy_after_accept", int'(busy), 1);
            wait_start(10);
            check("first_start_latency", last_start - acc, 2);
            if (tbl[i].n == 2) begin
                s1 = last_start;
                wait_start(40);
                check("back_to_back_gap", last_start - s1, 23);
            end
            wait_idle(60);
            check("busy_low_when_done", int'(busy), 0);
        end

        // 17 bytes into the core FIFO while the sender is busy with a debug byte
        reset_dut();
        sb.push_back(8'hEE);
        dbg_valid = 1'b1; dbg_data = 8'hEE;
        tick();
        dbg_valid = 1'b0;
        wait_start(10);
        for (int i = 0; i <= 16; i++) sb.push_back(8'(i));
        for (int i = 0; i <= 16; i++) begin
            core_valid = 1'b1;
            core_data  = 8'(i);
            n = 0;
            while (!core_ready && n < 100) begin
                tick();
                n++;
            end
            check("ready_timeout", int'(n < 100), 1);
            tick();
            if (i == 15) check("full_ready_low", int'(core_ready), 0);
        end
        core_valid = 1'b0;
        wait_idle(600);
        check("fill_all_sent", sb.size(), 0);

        // Reset mid-frame with five bytes still queued
        reset_dut();
        sb.push_back(8'hA0);
        for (int i = 0; i < 6; i++) begin
            core_valid = 1'b1;
            core_data  = 8'hA0 + 8'(i);
            tick();
        end
        core_valid = 1'b0;
        n = 0;
        while (tx_done && n < 20) begin
            tick();
            n++;
        end
        check("sender_busy_timeout", int'(n < 20), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ns = nstarts;
        check("midrst_busy", int'(busy), 0);
        check("midrst_core_ready", int'(core_ready), 1);
        check("midrst_tx_start", int'(tx_start), 0);
        check("midrst_sender_still_busy", int'(tx_done), 0);
        sb.push_back(8'h77);
        core_valid = 1'b1; core_data = 8'h77;
        tick();
        core_valid = 1'b0;
        wait_idle(60);
        check("midrst_one_start", nstarts - ns, 1);
        check("midrst_sb_empty", sb.size(), 0);

        // Core record C1,C2,C3 with debug byte arriving after C1 starts
        reset_dut();
`ifdef UART_TX_SCHED_LOCK_EN
        sb.push_back(8'hC1); sb.push_back(8'hC2); sb.push_back(8'hC3); sb.push_back(8'hD1);
`else
        sb.push_back(8'hC1); sb.push_back(8'hD1); sb.push_back(8'hC2); sb.push_back(8'hC3);
`endif
        for (int i = 0; i < 3; i++) begin
            core_valid = 1'b1;
            core_data  = 8'hC1 + 8'(i);
            core_last  = (i == 2);
            tick();
        end
        core_valid = 1'b0; core_last = 1'b1;
        wait_start(10);
        dbg_valid = 1'b1; dbg_data = 8'hD1; dbg_last = 1'b1;
        tick();
        dbg_valid = 1'b0;
        wait_idle(200);
        check("record_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
